// File: rtl/exc_ctx_stack.sv
// Exception context stack: saves {EPC, cause, mode} on each taken exception
// and pops on return-from-exception. Outputs always show the top context, or
// reset values when the stack is empty.
module exc_ctx_stack #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CAUSE_W  = 4,
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter bit          NEST_EN  = 1'b1,
    localparam int unsigned DW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   pc_8_in,
    input  logic               exc_req,
    input  logic [CAUSE_W-1:0] exc_cause,
    input  logic               adj_sel,
    input  logic               s_u,
    input  logic               rfe,
    output logic [WIDTH-1:0]   epc_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               prev_mode_out,
    output logic [DW-1:0]      depth_out,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [WIDTH-1:0] RST_EPC  = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] ADJ_TRAP = WIDTH'(4);
    localparam logic [WIDTH-1:0] ADJ_NORM = WIDTH'(8);
    localparam logic [DW-1:0]    D_ONE    = DW'(1);
    localparam logic [DW-1:0]    D_ZERO   = DW'(0);
    localparam logic [DW-1:0]    D_FULL   = DW'(DEPTH);

    logic [WIDTH-1:0]   epc_q   [DEPTH];
    logic [CAUSE_W-1:0] cause_q [DEPTH];
    logic               mode_q  [DEPTH];

    logic [DW-1:0]      depth_q, depth_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic               full_s, empty_s;
    logic               wr_en_s;
    logic [DW-1:0]      wr_idx_s;
    logic [WIDTH-1:0]   new_epc_s;

    // Decode stack state and compute the next depth, flags and entry write.
    always_comb begin
        full_s      = (depth_q == D_FULL);
        empty_s     = (depth_q == D_ZERO);
        new_epc_s   = pc_8_in - (adj_sel ? ADJ_TRAP : ADJ_NORM);
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = 1'b0;
        wr_en_s     = 1'b0;
        wr_idx_s    = depth_q;
        if (exc_req && rfe) begin
            // Replace the top entry; from empty this degenerates to a push.
            wr_en_s = 1'b1;
            if (empty_s) begin
                wr_idx_s = depth_q;
                depth_d  = depth_q + D_ONE;
            end else begin
                wr_idx_s = depth_q - D_ONE;
            end
        end else if (exc_req) begin
            if (full_s) begin
                overflow_d = 1'b1;
            end else if (NEST_EN || empty_s) begin
                wr_en_s  = 1'b1;
                wr_idx_s = depth_q;
                depth_d  = depth_q + D_ONE;
            end else begin
                depth_d = depth_q;
            end
        end else if (rfe) begin
            if (empty_s) begin
                underflow_d = 1'b1;
            end else begin
                depth_d = depth_q - D_ONE;
            end
        end else begin
            depth_d = depth_q;
        end
    end

    // Control state: depth and status flags, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            depth_q     <= D_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Context entries: written only on push or replace, never on reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (reset && wr_en_s && (wr_idx_s == DW'(i))) begin
                epc_q[i]   <= new_epc_s;
                cause_q[i] <= exc_cause;
                mode_q[i]  <= s_u;
            end
        end
    end

    // Select the top context from registers, or reset values when empty.
    always_comb begin
        epc_out       = RST_EPC;
        cause_out     = {CAUSE_W{1'b0}};
        prev_mode_out = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (depth_q == DW'(i + 1)) begin
                epc_out       = epc_q[i];
                cause_out     = cause_q[i];
                prev_mode_out = mode_q[i];
            end
        end
    end

    assign depth_out = depth_q;
    assign full      = (depth_q == D_FULL);
    assign empty     = (depth_q == D_ZERO);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_exc_ctx_stack.sv
// Randomized bench for exc_ctx_stack: two instances (nesting on / off) driven
// by the same stimulus and compared every cycle against a queue-style model.
module tb_exc_ctx_stack;

    typedef struct packed {
        logic [31:0] epc;
        logic [3:0]  cause;
        logic        mode;
    } ctx_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_8_in = 32'h0;
    logic        exc_req = 1'b0;
    logic [3:0]  exc_cause = 4'h0;
    logic        adj_sel = 1'b0;
    logic        s_u = 1'b0;
    logic        rfe = 1'b0;

    logic [31:0] epc0, epc1;
    logic [3:0]  cause0, cause1;
    logic        mode0, mode1;
    logic [2:0]  depth0, depth1;
    logic        full0, full1, empty0, empty1, ovf0, ovf1, udf0, udf1;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 1'b0;

    ctx_t stk [2][4];
    int   dep [2];
    bit   ov  [2];
    bit   ud  [2];

    always #5 clk = ~clk;

    exc_ctx_stack u_nest (
        .clk(clk), .reset(reset), .pc_8_in(pc_8_in), .exc_req(exc_req),
        .exc_cause(exc_cause), .adj_sel(adj_sel), .s_u(s_u), .rfe(rfe),
        .epc_out(epc0), .cause_out(cause0), .prev_mode_out(mode0),
        .depth_out(depth0), .full(full0), .empty(empty0),
        .overflow(ovf0), .underflow(udf0)
    );

    exc_ctx_stack #(.NEST_EN(1'b0)) u_flat (
        .clk(clk), .reset(reset), .pc_8_in(pc_8_in), .exc_req(exc_req),
        .exc_cause(exc_cause), .adj_sel(adj_sel), .s_u(s_u), .rfe(rfe),
        .epc_out(epc1), .cause_out(cause1), .prev_mode_out(mode1),
        .depth_out(depth1), .full(full1), .empty(empty1),
        .overflow(ovf1), .underflow(udf1)
    );

    // Apply one clock edge of the stack rules to model k.
    task automatic model_step(input int k);
        ctx_t c;
        bit   nest;
        nest    = (k == 0);
        c.epc   = pc_8_in - (adj_sel ? 32'd4 : 32'd8);
        c.cause = exc_cause;
        c.mode  = s_u;
        if (!reset) begin
            dep[k] = 0;
            ov[k]  = 1'b0;
            ud[k]  = 1'b0;
        end else begin
            ud[k] = 1'b0;
            if (exc_req && rfe) begin
                if (dep[k] > 0) stk[k][dep[k]-1] = c;
                else begin stk[k][0] = c; dep[k] = 1; end
            end else if (exc_req) begin
                if (dep[k] == 4) ov[k] = 1'b1;
                else if (nest || dep[k] == 0) begin stk[k][dep[k]] = c; dep[k]++; end
            end else if (rfe) begin
                if (dep[k] > 0) dep[k]--;
                else ud[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [43:0] expect_vec(input int k);
        ctx_t t;
        if (dep[k] == 0) begin
            t.epc = 32'h0001_0000; t.cause = 4'h0; t.mode = 1'b0;
        end else begin
            t = stk[k][dep[k]-1];
        end
        return {t.epc, t.cause, t.mode, 3'(dep[k]), dep[k] == 4, dep[k] == 0, ov[k], ud[k]};
    endfunction

    // Compare process: check both instances against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [43:0] a0, a1, e0, e1;
            a0 = {epc0, cause0, mode0, depth0, full0, empty0, ovf0, udf0};
            a1 = {epc1, cause1, mode1, depth1, full1, empty1, ovf1, udf1};
            e0 = expect_vec(0);
            e1 = expect_vec(1);
            vectors += 2;
            if (a0 !== e0) begin
                errors++;
                $display("FAIL nest_model t=%0t got=%h want=%h (epc,cause,mode,depth,full,empty,ovf,udf)", $time, a0, e0);
            end
            if (a1 !== e1) begin
                errors++;
                $display("FAIL flat_model t=%0t got=%h want=%h (epc,cause,mode,depth,full,empty,ovf,udf)", $time, a1, e1);
            end
        end
    end

    // Drive one cycle of inputs, advance the models at the edge.
    task automatic cyc(input bit rst_n, input bit exc, input bit ret,
                       input logic [31:0] pc, input bit adj,
                       input logic [3:0] cause, input bit su);
        @(negedge clk);
        reset = rst_n; exc_req = exc; rfe = ret; pc_8_in = pc;
        adj_sel = adj; exc_cause = cause; s_u = su;
        @(posedge clk);
        model_step(0);
        model_step(1);
        chk_en = 1'b1;
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        cyc(1'b1, 1'b1, 1'b0, pc, 1'b0, 4'h1, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        // Reset then idle.
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        lit("reset_epc", epc0, 32'h0001_0000);
        lit("reset_depth", 32'(depth0), 32'd0);
        lit("reset_flags", {empty0, full0, ovf0, udf0}, 32'b1000);

        // Single exception and return.
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_2008, 1'b0, 4'd3, 1'b1);
        lit("single_epc", epc0, 32'h0000_2000);
        lit("single_cause_mode_depth", {cause0, mode0, depth0}, {4'd3, 1'b1, 3'd1});
        pop();
        lit("single_ret_epc", epc0, 32'h0001_0000);
        lit("single_ret_empty", 32'(empty0), 32'd1);

        // Trap adjust and wrap-around; flat instance ignores the nested push.
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_2008, 1'b1, 4'd2, 1'b0);
        lit("trap_epc", epc0, 32'h0000_2004);
        cyc(1'b1, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 4'd5, 1'b0);
        lit("wrap_epc", epc0, 32'hFFFF_FFFC);
        lit("wrap_depth", 32'(depth0), 32'd2);
        lit("flat_ignored", {epc1, 3'b0, depth1}, {32'h0000_2004, 3'b0, 3'd1});
        lit("flat_no_ovf", 32'(ovf1), 32'd0);
        pop();
        pop();

        // Fill, overflow, drain.
        push(32'h108); push(32'h208); push(32'h308); push(32'h408);
        lit("full_flag", 32'(full0), 32'd1);
        push(32'h508);
        lit("ovf_epc", epc0, 32'h400);
        lit("ovf_flag", 32'(ovf0), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        lit("ovf_sticky", 32'(ovf0), 32'd1);
        pop(); lit("drain1", epc0, 32'h300);
        pop(); lit("drain2", epc0, 32'h200);
        pop(); lit("drain3", epc0, 32'h100);
        pop(); lit("drain4", epc0, 32'h0001_0000);

        // Replace at depth 2, then underflow from empty.
        push(32'h108); push(32'h208);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_0908, 1'b0, 4'd7, 1'b1);
        lit("replace_epc", epc0, 32'h900);
        lit("replace_depth", 32'(depth0), 32'd2);
        pop(); pop(); pop();
        lit("udf_pulse", {udf0, depth0}, {1'b1, 3'd0});
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        lit("udf_clear", 32'(udf0), 32'd0);

        // Reset mid-operation with a pending exception.
        push(32'h108); push(32'h208); push(32'h308);
        cyc(1'b0, 1'b1, 1'b0, 32'h0000_0A08, 1'b0, 4'h1, 1'b0);
        lit("midreset_depth", {29'b0, depth0}, 32'd0);
        lit("midreset_ovf", {ovf0, ovf1}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 40), pc, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
